// File: rtl/uart_rx_os16_if.sv
// Receiver-side bundle: serial line in, decoded byte and status out.
// The state field exposes the receiver FSM for observation.
interface uart_rx_os16_if;
  timeunit 1ns;
  timeprecision 1ps;

  logic       rx;
  logic [7:0] rxbyte;
  logic       ready;
  logic       ferr;
  logic       brk;
  logic       busy;
  logic [1:0] state;

  // rxbyte is valid on the clk where ready is high; there is no back-pressure,
  // so a consumer must take the byte in that same cycle (or read the held value later).
  modport master (output rx, input rxbyte, ready, ferr, brk, busy, state);
  modport slave  (input rx, output rxbyte, ready, ferr, brk, busy, state);
endinterface

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver, 16x oversampling with a 3-sample majority vote per bit,
// false-start rejection, framing-error pulse and break detection.
module uart_rx_os16 #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_os16_if.slave  bus
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int DIV_RND = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RND < 2) ? 2 : DIV_RND;
  localparam int DW      = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic          rx_meta_q, rx_s_q;
  logic [DW-1:0] div_q;
  logic [3:0]    s_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          smp7_q, smp8_q;
  logic          all0_q;
  logic [7:0]    rxbyte_q;
  logic          ready_q, ferr_q, brk_q;

  logic          tick;
  logic [3:0]    s_n;
  logic          maj;

  assign tick = (div_q == DW'(DIV - 1));
  // s_q holds the index of the last sample taken; the start-detect tick is sample 0.
  assign s_n  = s_q + 4'd1;
  assign maj  = (smp7_q & smp8_q) | (smp7_q & rx_s_q) | (smp8_q & rx_s_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
      s_q       <= 4'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      smp7_q    <= 1'b1;
      smp8_q    <= 1'b1;
      all0_q    <= 1'b0;
      rxbyte_q  <= 8'h00;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      div_q     <= tick ? '0 : div_q + 1'b1;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      if (tick) begin
        if (rx_s_q) brk_q <= 1'b0;
        if (state_q == IDLE) begin
          if (!rx_s_q && !brk_q) begin
            state_q <= START;
            s_q     <= 4'd0;
            all0_q  <= 1'b1;
          end
        end else begin
          s_q <= s_n;
          if (s_n == 4'd7) smp7_q <= rx_s_q;
          if (s_n == 4'd8) smp8_q <= rx_s_q;
          if (s_n == 4'd9) all0_q <= all0_q & ~maj;
          case (state_q)
            START: begin
              if (s_n == 4'd9 && maj) state_q <= IDLE;
              else if (s_n == 4'd15) begin
                state_q <= DATA;
                idx_q   <= 3'd0;
              end
            end
            DATA: begin
              if (s_n == 4'd9) shift_q[idx_q] <= maj;
              else if (s_n == 4'd15) begin
                if (idx_q == 3'd7) state_q <= STOP;
                else idx_q <= idx_q + 3'd1;
              end
            end
            STOP: begin
              // Leave at mid-stop so a back-to-back start edge is not missed.
              if (s_n == 4'd9) begin
                state_q <= IDLE;
                if (maj) begin
                  rxbyte_q <= shift_q;
                  ready_q  <= 1'b1;
                end else begin
                  ferr_q <= 1'b1;
                  if (all0_q) brk_q <= 1'b1;
                end
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.rxbyte = rxbyte_q;
  assign bus.ready  = ready_q;
  assign bus.ferr   = ferr_q;
  assign bus.brk    = brk_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.state  = state_q;
endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: good frames, false start, framing error,
// break, +/-3% baud back-to-back frames and mid-frame reset.
module tb_uart_rx_os16;
  timeunit 1ns;
  timeprecision 1ps;

  logic clk = 1'b0;
  logic reset;
  uart_rx_os16_if bus ();

  uart_rx_os16 dut (.clk(clk), .reset(reset), .bus(bus));

  always #20.833 clk = ~clk;

  real bit_ns = 1.0e9 / 115200.0;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  int   ready_cnt = 0, ferr_cnt = 0, busy_rise = 0;
  int   ready_long = 0, ferr_long = 0, both_cnt = 0;
  logic prev_ready = 1'b0, prev_ferr = 1'b0, prev_busy = 1'b0;
  logic ready_busy = 1'b1;
  real  ready_t = 0.0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the next expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.ready === 1'b1) begin
      ready_cnt++;
      ready_busy = bus.busy;
      ready_t    = $realtime;
      if (exp_q.size() == 0) check("unexpected_ready", {24'h0, bus.rxbyte}, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("rxbyte_at_ready", {24'h0, bus.rxbyte}, {24'h0, e});
      end
    end
    if (bus.ferr === 1'b1) ferr_cnt++;
    if (bus.ready === 1'b1 && prev_ready) ready_long++;
    if (bus.ferr === 1'b1 && prev_ferr) ferr_long++;
    if (bus.ready === 1'b1 && bus.ferr === 1'b1) both_cnt++;
    if (bus.busy === 1'b1 && !prev_busy) busy_rise++;
    prev_ready = bus.ready;
    prev_ferr  = bus.ferr;
    prev_busy  = bus.busy;
  end

  task automatic send_byte(input logic [7:0] b, input real bt, input logic stop_v);
    bus.rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      #(bt);
    end
    bus.rx = stop_v;
    #(bt);
    bus.rx = 1'b1;
  endtask

  initial begin
    int  r0, f0, b0;
    real t0, lat, fast, slow;
    fast = bit_ns / 1.03;
    slow = bit_ns / 0.97;

    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_rxbyte", {24'h0, bus.rxbyte}, 32'h00);
    check("reset_ready",  {31'h0, bus.ready}, 32'h0);
    check("reset_ferr",   {31'h0, bus.ferr},  32'h0);
    check("reset_brk",    {31'h0, bus.brk},   32'h0);
    check("reset_busy",   {31'h0, bus.busy},  32'h0);
    #(bit_ns);

    // T1: clean 0x67
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_rise;
    exp_q.push_back(8'h67);
    t0 = $realtime;
    send_byte(8'h67, bit_ns, 1'b1);
    #(2.0 * bit_ns);
    lat = ready_t - t0;
    check("T1_ready_pulses", ready_cnt - r0, 1);
    check("T1_ferr",         ferr_cnt - f0, 0);
    check("T1_busy_frames",  busy_rise - b0, 1);
    check("T1_busy_at_ready", {31'h0, ready_busy}, 32'h0);
    check("T1_latency_window", {31'h0, (lat > 9.45 * bit_ns) && (lat < 9.75 * bit_ns)}, 32'h1);
    check("T1_rxbyte", {24'h0, bus.rxbyte}, 32'h67);

    // T2: 3 us glitch is a false start
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_rise;
    bus.rx = 1'b0;
    #3000.0;
    bus.rx = 1'b1;
    #(2.0 * bit_ns);
    check("T2_busy_pulse", busy_rise - b0, 1);
    check("T2_no_ready",   ready_cnt - r0, 0);
    check("T2_no_ferr",    ferr_cnt - f0, 0);
    check("T2_rxbyte",     {24'h0, bus.rxbyte}, 32'h67);
    check("T2_busy_idle",  {31'h0, bus.busy}, 32'h0);

    // T3: 0x3D with low stop bit
    r0 = ready_cnt; f0 = ferr_cnt;
    send_byte(8'h3D, bit_ns, 1'b0);
    #(2.0 * bit_ns);
    check("T3_ferr",     ferr_cnt - f0, 1);
    check("T3_no_ready", ready_cnt - r0, 0);
    check("T3_rxbyte",   {24'h0, bus.rxbyte}, 32'h67);
    check("T3_no_brk",   {31'h0, bus.brk}, 32'h0);

    // T4: 200 us break, then 0x72
    r0 = ready_cnt; f0 = ferr_cnt; b0 = busy_rise;
    bus.rx = 1'b0;
    #190000.0;
    check("T4_brk_set",      {31'h0, bus.brk}, 32'h1);
    check("T4_busy_low",     {31'h0, bus.busy}, 32'h0);
    check("T4_one_ferr",     ferr_cnt - f0, 1);
    check("T4_one_frame",    busy_rise - b0, 1);
    check("T4_no_ready",     ready_cnt - r0, 0);
    #10000.0;
    bus.rx = 1'b1;
    #(2.0 * bit_ns);
    check("T4_brk_clear", {31'h0, bus.brk}, 32'h0);
    r0 = ready_cnt;
    exp_q.push_back(8'h72);
    send_byte(8'h72, bit_ns, 1'b1);
    #(2.0 * bit_ns);
    check("T4_ready_after", ready_cnt - r0, 1);
    check("T4_rxbyte",      {24'h0, bus.rxbyte}, 32'h72);

    // T5: back-to-back at +3% then -3%
    r0 = ready_cnt; f0 = ferr_cnt;
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h62);
    send_byte(8'h72, fast, 1'b1);
    send_byte(8'h62, fast, 1'b1);
    #(2.0 * bit_ns);
    check("T5_fast_ready", ready_cnt - r0, 2);
    check("T5_fast_rxbyte", {24'h0, bus.rxbyte}, 32'h62);
    r0 = ready_cnt;
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h62);
    send_byte(8'h72, slow, 1'b1);
    send_byte(8'h62, slow, 1'b1);
    #(2.0 * bit_ns);
    check("T5_slow_ready", ready_cnt - r0, 2);
    check("T5_slow_rxbyte", {24'h0, bus.rxbyte}, 32'h62);
    check("T5_no_ferr", ferr_cnt - f0, 0);

    // T6: reset during data bit 4 of 0x55, line then held idle
    r0 = ready_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i % 2 == 0);
      #(bit_ns);
    end
    bus.rx = 1'b1;
    #(0.5 * bit_ns);
    check("T6_busy_before_reset", {31'h0, bus.busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #(3.0 * bit_ns);
    check("T6_no_ready",  ready_cnt - r0, 0);
    check("T6_no_ferr",   ferr_cnt - f0, 0);
    check("T6_rxbyte",    {24'h0, bus.rxbyte}, 32'h00);
    check("T6_busy_idle", {31'h0, bus.busy}, 32'h0);
    r0 = ready_cnt;
    exp_q.push_back(8'h62);
    send_byte(8'h62, bit_ns, 1'b1);
    #(2.0 * bit_ns);
    check("T6_ready_after", ready_cnt - r0, 1);
    check("T6_rxbyte_after", {24'h0, bus.rxbyte}, 32'h62);

    check("exp_queue_drained", exp_q.size(), 0);
    check("ready_single_clk",  ready_long, 0);
    check("ferr_single_clk",   ferr_long, 0);
    check("ready_ferr_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
